// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sprite_pkg
// Purpose  : Shared constants, word map and commit FSM state type for the
//            sprite engine register path.
// Revision : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    localparam int SPR_NUM_WORDS = 10;
    localparam int SPR_DATA_W    = 16;
    localparam int SPR_IDX_W     = 4;

    // Shadow word map: two sprites, each {coord, bmp0..bmp3}
    localparam int SPR0_COORD = 0;
    localparam int SPR0_BMP0  = 1;
    localparam int SPR0_BMP1  = 2;
    localparam int SPR0_BMP2  = 3;
    localparam int SPR0_BMP3  = 4;
    localparam int SPR1_COORD = 5;
    localparam int SPR1_BMP0  = 6;
    localparam int SPR1_BMP1  = 7;
    localparam int SPR1_BMP2  = 8;
    localparam int SPR1_BMP3  = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COPY  = 2'd2,
        DONE  = 2'd3
    } commit_state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_shadow_regfile.sv
`default_nettype none
// ============================================================================
// Module   : sprite_shadow_regfile
// Purpose  : CPU-side shadow words with per-word dirty mask, a CPU read port
//            and a copy port whose clear loses to a same-cycle CPU write.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_shadow_regfile
    import sprite_pkg::*;
#(
    parameter int NUM_WORDS = SPR_NUM_WORDS,
    parameter int DATA_W    = SPR_DATA_W,
    parameter int IDX_W     = SPR_IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic [IDX_W-1:0]  cp_idx,
    output logic [DATA_W-1:0] cp_data,
    output logic              cp_dirty,
    input  logic              clr_en
);

    logic [DATA_W-1:0]    r_shadow [NUM_WORDS];
    logic [NUM_WORDS-1:0] r_dirty;

    // Index decode only matches in-range words, so out-of-range writes vanish
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
        logic w_set;
        logic w_clr;
        assign w_set = wr_en  && (wr_idx == IDX_W'(gi));
        assign w_clr = clr_en && (cp_idx == IDX_W'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_shadow[gi] <= '0;
                r_dirty[gi]  <= 1'b0;
            end else begin
                if (w_set) begin
                    r_shadow[gi] <= wr_data;
                end
                r_dirty[gi] <= w_set | (r_dirty[gi] & ~w_clr);
            end
        end
    end

    always_comb begin
        rd_data  = '0;
        cp_data  = '0;
        cp_dirty = 1'b0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = r_shadow[i];
            end
            if (cp_idx == IDX_W'(i)) begin
                cp_data  = r_shadow[i];
                cp_dirty = r_dirty[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_commit_sched.sv
`default_nettype none
// ============================================================================
// Module   : sprite_commit_sched
// Purpose  : Tear-free commit of dirty shadow words into the sprite engine's
//            live registers, one word per cycle starting at vblank.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_commit_sched
    import sprite_pkg::*;
#(
    parameter int NUM_WORDS = SPR_NUM_WORDS,
    parameter int DATA_W    = SPR_DATA_W,
    parameter int IDX_W     = SPR_IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_we,
    input  logic [IDX_W-1:0]  cpu_idx,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              commit_req,
    input  logic              irq_en,
    input  logic              irq_clr,
    input  logic              vblank,
    input  logic              vblank_start,
    output logic              eng_we,
    output logic [IDX_W-1:0]  eng_idx,
    output logic [DATA_W-1:0] eng_wdata,
    output logic              pending,
    output logic              busy,
    output logic              commit_done,
    output logic              irq
);

    commit_state_t     r_state;
    logic [IDX_W-1:0]  r_idx;
    logic              r_rearm;
    logic              r_eng_we;
    logic [IDX_W-1:0]  r_eng_idx;
    logic [DATA_W-1:0] r_eng_wdata;
    logic              r_irq;

    logic [DATA_W-1:0] w_cp_data;
    logic              w_cp_dirty;
    logic              w_copy;
    logic              w_last;

    // A word is copied only while blanking holds; an abort cycle leaves it dirty
    assign w_copy = (r_state == COPY) && vblank && w_cp_dirty;
    assign w_last = (r_idx == IDX_W'(NUM_WORDS - 1));

    sprite_shadow_regfile #(
        .NUM_WORDS (NUM_WORDS),
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W)
    ) u_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (cpu_we),
        .wr_idx   (cpu_idx),
        .wr_data  (cpu_wdata),
        .rd_idx   (cpu_idx),
        .rd_data  (cpu_rdata),
        .cp_idx   (r_idx),
        .cp_data  (w_cp_data),
        .cp_dirty (w_cp_dirty),
        .clr_en   (w_copy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_rearm     <= 1'b0;
            r_eng_we    <= 1'b0;
            r_eng_idx   <= '0;
            r_eng_wdata <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_eng_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (commit_req) begin
                        r_state <= ARMED;
                    end
                end
                ARMED: begin
                    if (vblank_start) begin
                        r_state <= COPY;
                        r_idx   <= '0;
                    end
                end
                COPY: begin
                    if (commit_req) begin
                        r_rearm <= 1'b1;
                    end
                    if (!vblank) begin
                        r_state <= ARMED;
                        r_idx   <= '0;
                    end else begin
                        if (w_cp_dirty) begin
                            r_eng_we    <= 1'b1;
                            r_eng_idx   <= r_idx;
                            r_eng_wdata <= w_cp_data;
                        end
                        if (w_last) begin
                            r_state <= DONE;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (r_rearm) begin
                        r_state <= ARMED;
                        r_rearm <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Set in DONE outranks a simultaneous clear
            if ((r_state == DONE) && irq_en) begin
                r_irq <= 1'b1;
            end else if (irq_clr) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign eng_we      = r_eng_we;
    assign eng_idx     = r_eng_idx;
    assign eng_wdata   = r_eng_wdata;
    assign pending     = (r_state == ARMED);
    assign busy        = (r_state == COPY);
    assign commit_done = (r_state == DONE);
    assign irq         = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_sprite_commit_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_commit_sched
// Purpose  : Directed self-checking bench for the sprite commit scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_commit_sched;

    logic        clk;
    logic        rst_n;
    logic        cpu_we;
    logic [3:0]  cpu_idx;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        commit_req;
    logic        irq_en;
    logic        irq_clr;
    logic        vblank;
    logic        vblank_start;
    logic        eng_we;
    logic [3:0]  eng_idx;
    logic [15:0] eng_wdata;
    logic        pending;
    logic        busy;
    logic        commit_done;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    // Per-cycle capture of one vblank pass; index k = cycles since vblank_start
    logic        we_log   [0:31];
    logic [3:0]  idx_log  [0:31];
    logic [15:0] dat_log  [0:31];
    logic        done_log [0:31];
    logic        busy_log [0:31];
    logic        pend_log [0:31];
    logic        irq_log  [0:31];
    logic [15:0] exp_d    [0:9];

    sprite_commit_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_we       (cpu_we),
        .cpu_idx      (cpu_idx),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .commit_req   (commit_req),
        .irq_en       (irq_en),
        .irq_clr      (irq_clr),
        .vblank       (vblank),
        .vblank_start (vblank_start),
        .eng_we       (eng_we),
        .eng_idx      (eng_idx),
        .eng_wdata    (eng_wdata),
        .pending      (pending),
        .busy         (busy),
        .commit_done  (commit_done),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [3:0] i, input logic [15:0] d);
        cpu_we = 1'b1; cpu_idx = i; cpu_wdata = d;
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic commit();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
    endtask

    // Pulses vblank_start at k=0 and records outputs for k=0..n
    task automatic do_pass(input int n, input int wr_at, input logic [3:0] wi,
                           input logic [15:0] wd, input int drop_at,
                           input int req_at, input int clr_at);
        vblank = 1'b1;
        for (int k = 0; k <= n; k++) begin
            vblank_start = (k == 0);
            cpu_we       = (k == wr_at);
            commit_req   = (k == req_at);
            irq_clr      = (k == clr_at);
            if (k == wr_at) begin
                cpu_idx = wi; cpu_wdata = wd;
            end
            if (k == drop_at) vblank = 1'b0;
            we_log[k]   = eng_we;
            idx_log[k]  = eng_idx;
            dat_log[k]  = eng_wdata;
            done_log[k] = commit_done;
            busy_log[k] = busy;
            pend_log[k] = pending;
            irq_log[k]  = irq;
            tick();
        end
        vblank_start = 1'b0; cpu_we = 1'b0; commit_req = 1'b0; irq_clr = 1'b0;
    endtask

    // Word i is expected on the engine port at k = 2 + i when mask[i] is set
    task automatic check_copy(input string tag, input int n, input logic [9:0] mask,
                              input int done_k);
        int cnt;
        cnt = 0;
        for (int k = 1; k <= n; k++) begin
            int  i;
            logic e;
            i = k - 2;
            e = (i >= 0) && (i < 10) && mask[i];
            check_val($sformatf("%s we k=%0d", tag, k), 32'(we_log[k]), 32'(e));
            if (e) begin
                check_val($sformatf("%s idx k=%0d", tag, k), 32'(idx_log[k]), 32'(i));
                check_val($sformatf("%s data k=%0d", tag, k), 32'(dat_log[k]), 32'(exp_d[i]));
            end
            if (done_k >= 0)
                check_val($sformatf("%s done k=%0d", tag, k), 32'(done_log[k]), 32'(k == done_k));
            if (we_log[k]) cnt++;
        end
        check_val({tag, " write count"}, 32'(cnt), 32'($countones(mask)));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, " eng_we"},      32'(eng_we),      32'd0);
        check_val({tag, " eng_idx"},     32'(eng_idx),     32'd0);
        check_val({tag, " eng_wdata"},   32'(eng_wdata),   32'd0);
        check_val({tag, " pending"},     32'(pending),     32'd0);
        check_val({tag, " busy"},        32'(busy),        32'd0);
        check_val({tag, " commit_done"}, 32'(commit_done), 32'd0);
        check_val({tag, " irq"},         32'(irq),         32'd0);
    endtask

    initial begin
        int bcnt;
        rst_n = 1'b0; cpu_we = 1'b0; cpu_idx = '0; cpu_wdata = '0;
        commit_req = 1'b0; irq_en = 1'b0; irq_clr = 1'b0;
        vblank = 1'b0; vblank_start = 1'b0;
        tick(); tick();
        check_idle_outputs("reset");
        check_val("reset rdata", 32'(cpu_rdata), 32'd0);
        rst_n = 1'b1;
        tick();

        // Full pass: all ten words dirty
        for (int i = 0; i < 10; i++) begin
            cpu_write(4'(i), 16'hA000 + 16'(i));
            exp_d[i] = 16'hA000 + 16'(i);
        end
        cpu_idx = 4'd5; #1;
        check_val("rdata idx5", 32'(cpu_rdata), 32'hA005);
        cpu_idx = 4'd12; #1;
        check_val("rdata idx12 out of range", 32'(cpu_rdata), 32'd0);
        cpu_write(4'd12, 16'hDEAD);
        cpu_idx = 4'd9; #1;
        check_val("rdata idx9 after oob write", 32'(cpu_rdata), 32'hA009);
        commit();
        check_val("armed pending", 32'(pending), 32'd1);
        do_pass(14, -1, 4'd0, 16'd0, -1, -1, -1);
        check_copy("full", 14, 10'h3FF, 11);
        bcnt = 0;
        for (int k = 0; k <= 14; k++) if (busy_log[k]) bcnt++;
        check_val("full busy cycles", 32'(bcnt), 32'd10);
        check_val("full busy at k1", 32'(busy_log[1]), 32'd1);
        check_val("full idle after", 32'(pend_log[13] | busy_log[13]), 32'd0);

        // Everything was cleaned, so an empty commit writes nothing
        commit();
        do_pass(14, -1, 4'd0, 16'd0, -1, -1, -1);
        check_copy("clean", 14, 10'h000, 11);

        // Sparse: words 3 and 7 only
        cpu_write(4'd3, 16'h0333); exp_d[3] = 16'h0333;
        cpu_write(4'd7, 16'h0777); exp_d[7] = 16'h0777;
        commit();
        do_pass(14, -1, 4'd0, 16'd0, -1, -1, -1);
        check_copy("sparse", 14, 10'h088, 11);
        bcnt = 0;
        for (int k = 0; k <= 14; k++) if (busy_log[k]) bcnt++;
        check_val("sparse busy cycles", 32'(bcnt), 32'd10);

        // Collision on word 2: engine sees old data, new data held for next pass
        cpu_write(4'd2, 16'h1111); exp_d[2] = 16'h1111;
        commit();
        do_pass(14, 3, 4'd2, 16'h2222, -1, -1, -1);
        check_copy("collide", 14, 10'h004, 11);
        cpu_idx = 4'd2; #1;
        check_val("collide rdata", 32'(cpu_rdata), 32'h2222);
        exp_d[2] = 16'h2222;
        commit();
        do_pass(14, -1, 4'd0, 16'd0, -1, -1, -1);
        check_copy("collide 2nd", 14, 10'h004, 11);

        // Abort: vblank drops at k=4 while word 3 is up
        for (int i = 0; i < 10; i++) begin
            cpu_write(4'(i), 16'hB000 + 16'(i));
            exp_d[i] = 16'hB000 + 16'(i);
        end
        commit();
        do_pass(12, -1, 4'd0, 16'd0, 4, -1, -1);
        check_copy("abort", 12, 10'h007, -1);
        check_val("abort pending", 32'(pend_log[5]), 32'd1);
        check_val("abort not busy", 32'(busy_log[5]), 32'd0);
        check_val("abort still pending", 32'(pending), 32'd1);
        do_pass(14, -1, 4'd0, 16'd0, -1, -1, -1);
        check_copy("resume", 14, 10'h3F8, 11);

        // Sticky irq, set beats same-cycle clear, irq_en=0 does not clear
        irq_en = 1'b1;
        cpu_write(4'd0, 16'h0C0C); exp_d[0] = 16'h0C0C;
        commit();
        do_pass(14, -1, 4'd0, 16'd0, -1, -1, -1);
        check_val("irq low in done", 32'(irq_log[11]), 32'd0);
        check_val("irq set after done", 32'(irq_log[12]), 32'd1);
        commit();
        do_pass(14, -1, 4'd0, 16'd0, -1, -1, 11);
        check_val("irq set beats clr", 32'(irq_log[12]), 32'd1);
        irq_en = 1'b0;
        tick();
        check_val("irq_en low keeps irq", 32'(irq), 32'd1);
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        check_val("irq cleared", 32'(irq), 32'd0);
        commit();
        do_pass(14, -1, 4'd0, 16'd0, -1, -1, -1);
        check_val("irq stays low with irq_en=0", 32'(irq), 32'd0);

        // commit_req during COPY re-arms after DONE
        cpu_write(4'd1, 16'h0101); exp_d[1] = 16'h0101;
        commit();
        do_pass(14, -1, 4'd0, 16'd0, -1, 5, -1);
        check_copy("rearm", 14, 10'h002, 11);
        check_val("rearm pending", 32'(pend_log[12]), 32'd1);
        check_val("rearm still pending", 32'(pending), 32'd1);

        // Reset mid-COPY clears everything asynchronously
        for (int i = 0; i < 10; i++) cpu_write(4'(i), 16'hC000 + 16'(i));
        vblank = 1'b1; vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        tick();
        check_val("pre-reset eng_we", 32'(eng_we), 32'd1);
        check_val("pre-reset eng_wdata", 32'(eng_wdata), 32'hC000);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async reset");
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        check_idle_outputs("post reset");
        cpu_idx = 4'd5; #1;
        check_val("post reset rdata", 32'(cpu_rdata), 32'd0);

        // commit_req with vblank_start while IDLE only arms
        commit_req = 1'b1; vblank_start = 1'b1;
        tick();
        commit_req = 1'b0; vblank_start = 1'b0;
        check_val("idle same-cycle pending", 32'(pending), 32'd1);
        check_val("idle same-cycle busy", 32'(busy), 32'd0);
        tick();
        check_val("idle same-cycle waits", 32'(pending), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
